// File: rtl/work_queue_dispatcher.sv
// work_queue_dispatcher: per-queue PC FIFOs with a round-robin dequeue FSM
// that hands the next program counter to the core on request.
module work_queue_dispatcher #(
    parameter int NUM_QUEUES = 16,
    parameter int DEPTH      = 8,
    parameter int PC_W       = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          queue_wen,
    input  logic [$clog2(NUM_QUEUES)-1:0] queue_number,
    input  logic [PC_W-1:0]               enq_pc,
    input  logic                          request_new_pc,
    output logic                          new_pc_valid,
    output logic [PC_W-1:0]               new_pc,
    output logic [$clog2(NUM_QUEUES)-1:0] new_pc_queue,
    output logic                          idle,
    output logic                          overflow
);
    localparam int QW = $clog2(NUM_QUEUES);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, WAIT, GRANT} state_t;
    state_t state, state_next;

    logic [PC_W-1:0] mem [NUM_QUEUES][DEPTH];
    logic [AW-1:0] head [NUM_QUEUES];
    logic [AW-1:0] tail [NUM_QUEUES];
    logic [CW-1:0] count [NUM_QUEUES];
    logic [QW-1:0] rr_ptr, sel, idx;
    logic [NUM_QUEUES-1:0] inc, dec, nz;
    logic found, deq, enq_ok;

    // First non-empty queue after rr_ptr; i=NUM_QUEUES wraps back onto rr_ptr itself.
    always_comb begin
        found = 1'b0;
        sel = '0;
        idx = '0;
        for (int i = 1; i <= NUM_QUEUES; i++) begin
            idx = rr_ptr + QW'(i);
            if (!found && count[idx] != '0) begin
                found = 1'b1;
                sel = idx;
            end
        end
    end

    assign deq = found && (state == WAIT || (state == IDLE && request_new_pc));
    assign enq_ok = queue_wen && (count[queue_number] != CW'(DEPTH) || (deq && sel == queue_number));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = request_new_pc ? (found ? GRANT : WAIT) : IDLE;
            WAIT:    state_next = found ? GRANT : WAIT;
            GRANT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= QW'(NUM_QUEUES - 1);
            new_pc       <= '0;
            new_pc_queue <= '0;
            overflow     <= 1'b0;
        end else begin
            state <= state_next;
            if (deq) begin
                rr_ptr       <= sel;
                new_pc       <= mem[sel][head[sel]];
                new_pc_queue <= sel;
            end
            if (queue_wen && !enq_ok)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk)
        if (enq_ok)
            mem[queue_number][tail[queue_number]] <= enq_pc;

    for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_q
        assign inc[g] = enq_ok && queue_number == QW'(g);
        assign dec[g] = deq && sel == QW'(g);
        assign nz[g]  = count[g] != '0;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                head[g]  <= '0;
                tail[g]  <= '0;
                count[g] <= '0;
            end else begin
                if (inc[g])
                    tail[g] <= tail[g] + 1'b1;
                if (dec[g])
                    head[g] <= head[g] + 1'b1;
                count[g] <= count[g] + CW'(inc[g]) - CW'(dec[g]);
            end
        end
    end

    assign new_pc_valid = state == GRANT;
    assign idle = !(|nz) && state == IDLE;
endmodule

// File: tb/tb_work_queue_dispatcher.sv
// tb_work_queue_dispatcher: directed checks of enqueue, round-robin grants,
// overflow, full-queue bypass, the WAIT path and reset during WAIT.
module tb_work_queue_dispatcher;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        queue_wen = 1'b0;
    logic [3:0]  queue_number = '0;
    logic [15:0] enq_pc = '0;
    logic        request_new_pc = 1'b0;
    logic        new_pc_valid;
    logic [15:0] new_pc;
    logic [3:0]  new_pc_queue;
    logic        idle;
    logic        overflow;
    int checks = 0;
    int errors = 0;

    work_queue_dispatcher dut (
        .clk(clk), .rst(rst), .queue_wen(queue_wen), .queue_number(queue_number),
        .enq_pc(enq_pc), .request_new_pc(request_new_pc), .new_pc_valid(new_pc_valid),
        .new_pc(new_pc), .new_pc_queue(new_pc_queue), .idle(idle), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        queue_wen = 1'b0;
        request_new_pc = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic enq(input logic [3:0] q, input logic [15:0] pc);
        queue_wen = 1'b1;
        queue_number = q;
        enq_pc = pc;
        @(negedge clk);
        queue_wen = 1'b0;
    endtask

    task automatic req_grant(input string tag, input logic [15:0] pc, input logic [3:0] q);
        request_new_pc = 1'b1;
        @(negedge clk);
        request_new_pc = 1'b0;
        check({tag, "_valid"}, 32'(new_pc_valid), 32'd1);
        check({tag, "_pc"}, 32'(new_pc), 32'(pc));
        check({tag, "_q"}, 32'(new_pc_queue), 32'(q));
        @(negedge clk);
        check({tag, "_strobe_end"}, 32'(new_pc_valid), 32'd0);
    endtask

    initial begin
        @(negedge clk);
        check("rst_valid", 32'(new_pc_valid), 32'd0);
        check("rst_pc", 32'(new_pc), 32'd0);
        check("rst_q", 32'(new_pc_queue), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;

        enq(4'd3, 16'h0100);
        check("basic_busy", 32'(idle), 32'd0);
        req_grant("basic", 16'h0100, 4'd3);
        check("basic_idle", 32'(idle), 32'd1);

        do_reset();
        enq(4'd0, 16'h00A0);
        enq(4'd5, 16'h00B0);
        enq(4'd0, 16'h00C0);
        req_grant("rr0", 16'h00A0, 4'd0);
        req_grant("rr1", 16'h00B0, 4'd5);
        req_grant("rr2", 16'h00C0, 4'd0);

        do_reset();
        for (int i = 0; i < 8; i++) enq(4'd2, 16'h0200 + 16'(i));
        check("full_no_ovf", 32'(overflow), 32'd0);
        enq(4'd2, 16'h02EE);
        check("full_ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < 8; i++) req_grant($sformatf("full%0d", i), 16'h0200 + 16'(i), 4'd2);
        enq(4'd2, 16'h02FF);
        req_grant("wrap", 16'h02FF, 4'd2);
        check("ovf_sticky", 32'(overflow), 32'd1);

        do_reset();
        for (int i = 0; i < 8; i++) enq(4'd1, 16'h0010 + 16'(i));
        request_new_pc = 1'b1;
        queue_wen = 1'b1;
        queue_number = 4'd1;
        enq_pc = 16'h0077;
        @(negedge clk);
        request_new_pc = 1'b0;
        queue_wen = 1'b0;
        check("sim_valid", 32'(new_pc_valid), 32'd1);
        check("sim_pc", 32'(new_pc), 32'h10);
        check("sim_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        for (int i = 1; i < 8; i++) req_grant($sformatf("sim%0d", i), 16'h0010 + 16'(i), 4'd1);
        req_grant("sim_last", 16'h0077, 4'd1);
        request_new_pc = 1'b1;
        @(negedge clk);
        request_new_pc = 1'b0;
        @(negedge clk);
        check("sim_empty", 32'(new_pc_valid), 32'd0);

        do_reset();
        request_new_pc = 1'b1;
        @(negedge clk);
        request_new_pc = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("wait_nogrant%0d", i), 32'(new_pc_valid), 32'd0);
            check($sformatf("wait_busy%0d", i), 32'(idle), 32'd0);
            @(negedge clk);
        end
        enq(4'd7, 16'h0200);
        check("wait_edge1", 32'(new_pc_valid), 32'd0);
        @(negedge clk);
        check("wait_valid", 32'(new_pc_valid), 32'd1);
        check("wait_pc", 32'(new_pc), 32'h0200);
        check("wait_q", 32'(new_pc_queue), 32'd7);
        @(negedge clk);
        check("wait_strobe_end", 32'(new_pc_valid), 32'd0);
        check("wait_idle", 32'(idle), 32'd1);

        request_new_pc = 1'b1;
        @(negedge clk);
        request_new_pc = 1'b0;
        @(negedge clk);
        check("midwait_busy", 32'(idle), 32'd0);
        #2 rst = 1'b1;
        #1 check("midwait_async", 32'(idle), 32'd1);
        #2 rst = 1'b0;
        @(negedge clk);
        enq(4'd7, 16'h0300);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("midwait_nogrant%0d", i), 32'(new_pc_valid), 32'd0);
            @(negedge clk);
        end
        check("midwait_pending", 32'(idle), 32'd0);
        req_grant("after_rst", 16'h0300, 4'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
